// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared types for the next-PC unit: PC source select encoding, PC unit state
// encoding and the default datapath width.
// Optional feature macro used by the files importing this package: RVC_EN.
// -----------------------------------------------------------------------------
package core_pkg;

    localparam int XLEN_DEFAULT = 32;

    // Source of the next PC, matching the 2-bit pc_src encoding.
    typedef enum logic [1:0] {
        PC_SEQ  = 2'b00,
        PC_BR   = 2'b01,
        PC_JAL  = 2'b10,
        PC_JALR = 2'b11
    } pc_src_e;

    // BOOT: first fetch not yet issued; RUN: real fetches; TRAP: one bubble.
    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        TRAP = 2'b10
    } pc_state_e;

endpackage

// File: rtl/pc_next_unit_if.sv
// -----------------------------------------------------------------------------
// pc_next_unit_if
// Bundles the control/target inputs and the PC-side outputs of pc_next_unit.
//   master : drives stall, pc_src, pc_branch, alu_result, redir_valid,
//            redir_target (and is_compressed when RVC_EN is defined);
//            observes pc, pc_plus4, fetch_valid, misalign, misalign_addr,
//            redir_count.
//   slave  : the pc_next_unit side (mirror of master).
// Optional feature macro: RVC_EN adds is_compressed.
// -----------------------------------------------------------------------------
interface pc_next_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
`ifdef RVC_EN
    logic             is_compressed;
`endif
    logic             stall;
    logic [1:0]       pc_src;
    logic [XLEN-1:0]  pc_branch;
    logic [XLEN-1:0]  alu_result;
    logic             redir_valid;
    logic [XLEN-1:0]  redir_target;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_plus4;
    logic             fetch_valid;
    logic             misalign;
    logic [XLEN-1:0]  misalign_addr;
    logic [CNT_W-1:0] redir_count;

    modport master (
`ifdef RVC_EN
        output is_compressed,
`endif
        output stall, pc_src, pc_branch, alu_result, redir_valid, redir_target,
        input  pc, pc_plus4, fetch_valid, misalign, misalign_addr, redir_count
    );

    modport slave (
`ifdef RVC_EN
        input  is_compressed,
`endif
        input  stall, pc_src, pc_branch, alu_result, redir_valid, redir_target,
        output pc, pc_plus4, fetch_valid, misalign, misalign_addr, redir_count
    );
endinterface

// File: rtl/pc_target_sel.sv
// -----------------------------------------------------------------------------
// pc_target_sel
// Combinational next-PC target select plus misalignment flag.
//   pc_src_i     : source select (seq / branch / JAL / JALR)
//   pc_plus4_i   : sequential successor
//   pc_branch_i  : branch/JAL target
//   alu_result_i : JALR target before LSB clear
//   target_o     : selected target
//   misalign_o   : non-sequential target not aligned to the fetch granule
// Optional feature macro: RVC_EN (halfword alignment instead of word).
// -----------------------------------------------------------------------------
module pc_target_sel
    import core_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  pc_src_e         pc_src_i,
    input  logic [XLEN-1:0] pc_plus4_i,
    input  logic [XLEN-1:0] pc_branch_i,
    input  logic [XLEN-1:0] alu_result_i,
    output logic [XLEN-1:0] target_o,
    output logic            misalign_o
);

    logic [XLEN-1:0] target_s;
    logic            unaligned_s;

    // Source mux; JALR drops bit 0 before the alignment check sees it.
    always_comb begin
        target_s = pc_plus4_i;
        case (pc_src_i)
            PC_SEQ:  target_s = pc_plus4_i;
            PC_BR:   target_s = pc_branch_i;
            PC_JAL:  target_s = pc_branch_i;
            PC_JALR: target_s = {alu_result_i[XLEN-1:1], 1'b0};
            default: target_s = pc_plus4_i;
        endcase
    end

    // Alignment granule: halfword with compressed support, word otherwise.
    always_comb begin
`ifdef RVC_EN
        unaligned_s = target_s[0];
`else
        unaligned_s = (target_s[1:0] != 2'b00);
`endif
    end

    assign target_o   = target_s;
    assign misalign_o = (pc_src_i != PC_SEQ) && unaligned_s;

endmodule

// File: rtl/pc_next_unit.sv
// -----------------------------------------------------------------------------
// pc_next_unit
// Owns the architectural PC. Chooses the next PC from sequential, branch, JAL,
// JALR or an external redirect, traps misaligned control-flow targets to
// TRAP_VECTOR with a one-cycle bubble, and counts non-sequential updates.
//   clk  : core clock
//   rst  : synchronous active-high reset (overrides stall)
//   bus  : pc_next_unit_if.slave (control inputs, PC-side outputs)
// Optional feature macro: RVC_EN (is_compressed selects +2/+4 increment and
// relaxes alignment to halfword).
// -----------------------------------------------------------------------------
module pc_next_unit
    import core_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0004),
    parameter int              CNT_W        = 16
) (
    input  logic            clk,
    input  logic            rst,
    pc_next_unit_if.slave   bus
);

    logic [XLEN-1:0]  pc_q, pc_d;
    pc_state_e        state_q, state_d;
    logic             fetch_valid_q, fetch_valid_d;
    logic             misalign_q, misalign_d;
    logic [XLEN-1:0]  maddr_q, maddr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_inc_s;
    logic [XLEN-1:0]  incr_s;
    logic [XLEN-1:0]  pc_plus4_s;
    logic [XLEN-1:0]  target_s;
    logic             target_misalign_s;

    // Sequential increment: 2 for compressed instructions when enabled.
    always_comb begin
`ifdef RVC_EN
        if (bus.is_compressed) begin
            incr_s = XLEN'(32'd2);
        end else begin
            incr_s = XLEN'(32'd4);
        end
`else
        incr_s = XLEN'(32'd4);
`endif
    end

    assign pc_plus4_s = pc_q + incr_s;

    pc_target_sel #(.XLEN(XLEN)) u_target_sel (
        .pc_src_i     (pc_src_e'(bus.pc_src)),
        .pc_plus4_i   (pc_plus4_s),
        .pc_branch_i  (bus.pc_branch),
        .alu_result_i (bus.alu_result),
        .target_o     (target_s),
        .misalign_o   (target_misalign_s)
    );

    // Next-state decision: redirect beats misaligned trap beats normal select.
    always_comb begin
        pc_d       = pc_q;
        state_d    = state_q;
        maddr_d    = maddr_q;
        misalign_d = 1'b0;
        cnt_inc_s  = 1'b0;
        if (bus.stall) begin
            pc_d = pc_q;
        end else begin
            case (state_q)
                BOOT: begin
                    state_d = RUN;
                end
                RUN: begin
                    if (bus.redir_valid) begin
                        pc_d      = bus.redir_target;
                        cnt_inc_s = 1'b1;
                    end else if (target_misalign_s) begin
                        pc_d       = TRAP_VECTOR;
                        maddr_d    = target_s;
                        misalign_d = 1'b1;
                        state_d    = TRAP;
                        cnt_inc_s  = 1'b1;
                    end else begin
                        pc_d      = target_s;
                        cnt_inc_s = (bus.pc_src != 2'b00);
                    end
                end
                TRAP: begin
                    state_d = RUN;
                    if (bus.redir_valid) begin
                        pc_d      = bus.redir_target;
                        cnt_inc_s = 1'b1;
                    end else begin
                        pc_d = pc_q;
                    end
                end
                default: begin
                    state_d = BOOT;
                    pc_d    = RESET_VECTOR;
                end
            endcase
        end
    end

    // Saturating counter and registered fetch_valid decode.
    always_comb begin
        if (cnt_inc_s && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        fetch_valid_d = (state_d == RUN);
    end

    // State, PC and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_VECTOR;
            state_q       <= BOOT;
            fetch_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
            maddr_q       <= {XLEN{1'b0}};
            cnt_q         <= {CNT_W{1'b0}};
        end else begin
            pc_q          <= pc_d;
            state_q       <= state_d;
            fetch_valid_q <= fetch_valid_d;
            misalign_q    <= misalign_d;
            maddr_q       <= maddr_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus.pc            = pc_q;
    assign bus.pc_plus4      = pc_plus4_s;
    assign bus.fetch_valid   = fetch_valid_q;
    assign bus.misalign      = misalign_q;
    assign bus.misalign_addr = maddr_q;
    assign bus.redir_count   = cnt_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_next_unit
// Scoreboard bench: the driver applies one input vector per cycle and queues
// the architecturally expected outputs; a monitor pops and compares them on
// the falling edge. Directed sequence first, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_pc_next_unit;
    import core_pkg::*;

    localparam int          XLEN  = 32;
    localparam int          CNT_W = 3;
    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam logic [31:0] TV    = 32'h0000_0004;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_next_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    pc_next_unit #(
        .XLEN(XLEN), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        fv;
        logic        mis;
        logic [31:0] maddr;
        int          cnt;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: 0 = not yet reset, 1 = boot, 2 = running, 3 = bubble.
    int          m_mode = 0;
    logic [31:0] m_pc;
    logic        m_mis;
    logic [31:0] m_maddr;
    int          m_cnt;

    function automatic int cur_inc();
`ifdef RVC_EN
        return bus.is_compressed ? 2 : 4;
`else
        return 4;
`endif
    endfunction

    function automatic bit bad_align(input logic [31:0] t);
`ifdef RVC_EN
        return t[0];
`else
        return t[1:0] != 2'b00;
`endif
    endfunction

    task automatic bump();
        if (m_cnt < CMAX) m_cnt++;
    endtask

    // Advance the model by one clock edge using the currently applied inputs.
    task automatic model_edge();
        logic [31:0] t;
        if (rst) begin
            m_mode = 1; m_pc = RV; m_mis = 1'b0; m_maddr = 32'h0; m_cnt = 0;
            return;
        end
        if (m_mode == 0) return;
        m_mis = 1'b0;
        if (bus.stall) return;
        if (m_mode == 1) begin
            m_mode = 2;
        end else if (m_mode == 3) begin
            m_mode = 2;
            if (bus.redir_valid) begin m_pc = bus.redir_target; bump(); end
        end else if (bus.redir_valid) begin
            m_pc = bus.redir_target; bump();
        end else begin
            if (bus.pc_src == 2'd0)      t = m_pc + 32'(cur_inc());
            else if (bus.pc_src == 2'd3) t = bus.alu_result & 32'hFFFF_FFFE;
            else                         t = bus.pc_branch;
            if (bus.pc_src != 2'd0 && bad_align(t)) begin
                m_pc = TV; m_maddr = t; m_mis = 1'b1; m_mode = 3; bump();
            end else begin
                m_pc = t;
                if (bus.pc_src != 2'd0) bump();
            end
        end
    endtask

    // One cycle: apply inputs, queue expectations for this cycle, step model.
    task automatic apply(input bit r, input bit st, input logic [1:0] src,
                         input logic [31:0] br, input logic [31:0] alu,
                         input bit rv, input logic [31:0] rt);
        exp_t e;
        rst = r;
        bus.stall = st; bus.pc_src = src; bus.pc_branch = br;
        bus.alu_result = alu; bus.redir_valid = rv; bus.redir_target = rt;
        if (m_mode != 0) begin
            e.pc = m_pc; e.pc_plus4 = m_pc + 32'(cur_inc());
            e.fv = (m_mode == 2); e.mis = m_mis; e.maddr = m_maddr; e.cnt = m_cnt;
            q.push_back(e);
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic seq(input int n);
        for (int i = 0; i < n; i++) apply(0, 0, 2'd0, 32'h0, 32'h0, 0, 32'h0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp_v);
        end
    endtask

    // Monitor: compare every presented cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc", bus.pc, e.pc);
                chk("pc_plus4", bus.pc_plus4, e.pc_plus4);
                chk("fetch_valid", 32'(bus.fetch_valid), 32'(e.fv));
                chk("misalign", 32'(bus.misalign), 32'(e.mis));
                chk("misalign_addr", bus.misalign_addr, e.maddr);
                chk("redir_count", 32'(bus.redir_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        logic [31:0] br, alu, rt;
`ifdef RVC_EN
        bus.is_compressed = 1'b0;
`endif
        // Reset then free-running sequential fetch.
        apply(1, 0, 2'd0, 32'h0, 32'h0, 0, 32'h0);
        seq(3);
        // Redirect to 0x10, then taken branch to 0x40.
        apply(0, 0, 2'd0, 32'h0, 32'h0, 1, 32'h10);
        apply(0, 0, 2'd1, 32'h40, 32'h0, 0, 32'h0);
        // JALR to an odd address: LSB cleared, no trap.
        apply(0, 0, 2'd3, 32'h0, 32'h101, 0, 32'h0);
        // Misaligned branch: trap, bubble, resume.
        apply(0, 0, 2'd1, 32'h42, 32'h0, 0, 32'h0);
        apply(0, 0, 2'd1, 32'h80, 32'h0, 0, 32'h0);
        seq(2);
        // Redirect beats a misaligned branch.
        apply(0, 0, 2'd1, 32'h42, 32'h0, 1, 32'h200);
        // Stall holds everything; redirect while stalled is dropped.
        apply(0, 1, 2'd1, 32'h40, 32'h0, 1, 32'h300);
        apply(0, 1, 2'd1, 32'h40, 32'h0, 0, 32'h0);
        apply(0, 1, 2'd0, 32'h0, 32'h0, 0, 32'h0);
        // Reset wins over stall.
        apply(1, 1, 2'd0, 32'h0, 32'h0, 0, 32'h0);
        seq(2);
        // Wrap of the sequential successor.
        apply(0, 0, 2'd0, 32'h0, 32'h0, 1, 32'hFFFF_FFFC);
        seq(2);
        // Saturate the redirect counter.
        for (int i = 0; i < CMAX + 3; i++) apply(0, 0, 2'd2, 32'(i * 16), 32'h0, 0, 32'h0);
        // Misaligned trap while stalled on the bubble, redirect inside TRAP.
        apply(0, 0, 2'd2, 32'h1002, 32'h0, 0, 32'h0);
        apply(0, 1, 2'd0, 32'h0, 32'h0, 0, 32'h0);
        apply(0, 0, 2'd0, 32'h0, 32'h0, 1, 32'h500);
        seq(1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            br  = $urandom();
            alu = $urandom();
            rt  = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) != 0) br = br & 32'hFFFF_FFFC;
            if ($urandom_range(0, 15) == 0) rt = 32'hFFFF_FFFC;
`ifdef RVC_EN
            bus.is_compressed = 1'($urandom_range(0, 1));
`endif
            apply(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
                  2'($urandom_range(0, 3)), br, alu,
                  ($urandom_range(0, 15) == 0), rt);
        end
        seq(1);

        repeat (2) @(negedge clk);
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
